// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD engine.
//   gcd_state_t     : controller state encoding (IDLE, RUN, DONE)
//   gcd_max_latency : worst-case cycles from start edge to done for the
//                     binary (Stein) datapath at a given operand width
// Configuration macro: GCD_BINARY_EN (consumed by gcd_step / gcd_engine).
// ---------------------------------------------------------------------------
package gcd_pkg;

    typedef enum logic [1:0] {
        GCD_IDLE = 2'd0,
        GCD_RUN  = 2'd1,
        GCD_DONE = 2'd2
    } gcd_state_t;

    // Each binary step removes at least one bit from a or b, plus the
    // final finish-detect cycle.
    function automatic int gcd_max_latency(input int width);
        return 2 * width + 1;
    endfunction

endpackage : gcd_pkg

// File: rtl/gcd_step.sv
// ---------------------------------------------------------------------------
// gcd_step
// Combinational single iteration of the GCD loop plus finish detection.
// Configuration macro: GCD_BINARY_EN
//   defined   : binary (Stein) step, carries the shared power-of-two count k
//   undefined : subtractive Euclid step, no k path
// Ports:
//   a, b    in  WIDTH  current operand registers
//   k       in  CNT_W  shared power-of-two count (binary mode only)
//   k_nxt   out CNT_W  next k (binary mode only)
//   a_nxt   out WIDTH  next a
//   b_nxt   out WIDTH  next b
//   fin     out 1      a==0, b==0 or a==b: result is ready
//   zero    out 1      both operands are zero
//   res     out WIDTH  result to latch when fin is high
// ---------------------------------------------------------------------------
module gcd_step #(
    parameter int WIDTH = 32
`ifdef GCD_BINARY_EN
   ,parameter int CNT_W = $clog2(WIDTH) + 1
`endif
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef GCD_BINARY_EN
    input  logic [CNT_W-1:0] k,
    output logic [CNT_W-1:0] k_nxt,
`endif
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic             fin,
    output logic             zero,
    output logic [WIDTH-1:0] res
);

    logic             a_zero;
    logic             b_zero;
    logic             a_gt_b;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;
    logic [WIDTH-1:0] base;

    assign a_zero  = (a == '0);
    assign b_zero  = (b == '0);
    assign a_gt_b  = (a > b);
    // Only the difference with the larger minuend is ever selected, so
    // neither selected result wraps.
    assign diff_ab = a - b;
    assign diff_ba = b - a;

    assign fin  = a_zero | b_zero | (a == b);
    assign zero = a_zero & b_zero;
    assign base = a_zero ? b : a;

`ifdef GCD_BINARY_EN
    assign res = base << k;
`else
    assign res = base;
`endif

    always_comb begin
        // NOTE: every output gets a default before the branches so no path
        // leaves it unassigned, which would otherwise infer a latch.
        a_nxt = a;
        b_nxt = b;
`ifdef GCD_BINARY_EN
        k_nxt = k;
        if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            k_nxt = k + CNT_W'(1);
        end else if (!a[0]) begin
            a_nxt = a >> 1;
        end else if (!b[0]) begin
            b_nxt = b >> 1;
        end else if (a_gt_b) begin
            // odd - odd is even, so the shift drops no information
            a_nxt = diff_ab >> 1;
        end else begin
            b_nxt = diff_ba >> 1;
        end
`else
        if (a_gt_b) begin
            a_nxt = diff_ab;
        end else begin
            b_nxt = diff_ba;
        end
`endif
    end

endmodule : gcd_step

// File: rtl/gcd_engine.sv
// ---------------------------------------------------------------------------
// gcd_engine
// Iterative GCD of two unsigned WIDTH-bit operands with a level go / sticky
// done handshake. Synchronous active-high reset.
// Configuration macro: GCD_BINARY_EN selects the binary (Stein) datapath;
// the default build uses the subtractive Euclid datapath.
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous active-high reset
//   go    in  1      start request, sampled in IDLE and DONE
//   in1   in  WIDTH  operand A, captured on the start edge
//   in2   in  WIDTH  operand B, captured on the start edge
//   out   out WIDTH  GCD result, held until the next result
//   done  out 1      result valid (DONE state)
//   busy  out 1      computing (RUN state)
//   err   out 1      both operands were zero; valid with done
// ---------------------------------------------------------------------------
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy,
    output logic             err
);

    if (WIDTH < 2 || CNT_W < 1) begin : g_param_check
        $error("gcd_engine: WIDTH must be >= 2 and CNT_W >= 1");
    end

    gcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, a_nxt;
    logic [WIDTH-1:0] b_q, b_d, b_nxt;
    logic [WIDTH-1:0] out_d, res;
    logic             err_d, fin, zero;
`ifdef GCD_BINARY_EN
    logic [CNT_W-1:0] k_q, k_d, k_nxt;
`endif

    gcd_step #(
        .WIDTH (WIDTH)
`ifdef GCD_BINARY_EN
       ,.CNT_W (CNT_W)
`endif
    ) u_step (
        .a     (a_q),
        .b     (b_q),
`ifdef GCD_BINARY_EN
        .k     (k_q),
        .k_nxt (k_nxt),
`endif
        .a_nxt (a_nxt),
        .b_nxt (b_nxt),
        .fin   (fin),
        .zero  (zero),
        .res   (res)
    );

    assign done = (state_q == GCD_DONE);
    assign busy = (state_q == GCD_RUN);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out;
        err_d   = err;
`ifdef GCD_BINARY_EN
        k_d     = k_q;
`endif
        case (state_q)
            GCD_IDLE, GCD_DONE: begin
                if (go) begin
                    state_d = GCD_RUN;
                    a_d     = in1;
                    b_d     = in2;
                    err_d   = 1'b0;
`ifdef GCD_BINARY_EN
                    k_d     = '0;
`endif
                end
            end
            GCD_RUN: begin
                // Finish check has priority: stepping with a zero operand
                // would never terminate.
                if (fin) begin
                    state_d = GCD_DONE;
                    out_d   = res;
                    err_d   = zero;
                end else begin
                    a_d = a_nxt;
                    b_d = b_nxt;
`ifdef GCD_BINARY_EN
                    k_d = k_nxt;
`endif
                end
            end
            default: state_d = GCD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GCD_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out     <= '0;
            err     <= 1'b0;
`ifdef GCD_BINARY_EN
            k_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out     <= out_d;
            err     <= err_d;
`ifdef GCD_BINARY_EN
            k_q     <= k_d;
`endif
        end
    end

endmodule : gcd_engine

// File: tb/tb_gcd_engine.sv
// ---------------------------------------------------------------------------
// tb_gcd_engine
// Self-checking bench for gcd_engine (WIDTH=32 main instance, WIDTH=8 second
// instance). Expected results come from a modulo-based Euclid model and are
// queued at start time, then popped when done rises.
// Works in either build; GCD_BINARY_EN selects the expected latencies.
// ---------------------------------------------------------------------------
module tb_gcd_engine;
    import gcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [31:0] in1, in2, out;
    logic        done, busy, err;
    logic        go8;
    logic [7:0]  in1_8, in2_8, out8;
    logic        done8, busy8, err8;

    int total = 0;
    int bad   = 0;

`ifdef GCD_BINARY_EN
    localparam int LAT_16_42 = 9;
`else
    localparam int LAT_16_42 = 7;
`endif

    typedef struct {
        logic [31:0] out;
        logic        err;
        int          lat_max;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(32)) u_dut (
        .clk (clk), .rst (rst), .go (go), .in1 (in1), .in2 (in2),
        .out (out), .done (done), .busy (busy), .err (err)
    );

    gcd_engine #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst (rst), .go (go8), .in1 (in1_8), .in2 (in2_8),
        .out (out8), .done (done8), .busy (busy8), .err (err8)
    );

    function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int lat_bound(input logic [31:0] x, input logic [31:0] y, input int w);
`ifdef GCD_BINARY_EN
        return gcd_max_latency(w);
`else
        return int'((x > y) ? x : y) + 1;
`endif
    endfunction

    task automatic push_exp(input string name, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.out     = ref_gcd(x, y);
        e.err     = (x == 0) && (y == 0);
        e.lat_max = lat_bound(x, y, 32);
        e.name    = name;
        exp_q.push_back(e);
    endtask

    // Queue expectation, present operands for exactly one start edge.
    task automatic start32(input string name, input logic [31:0] x, input logic [31:0] y);
        push_exp(name, x, y);
        in1 = x;
        in2 = y;
        go  = 1'b1;
        @(posedge clk); #1;
        go  = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        exp_t e;
        int   limit;
        lat = 0;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: no expected result queued");
            return;
        end
        e = exp_q.pop_front();
        limit = e.lat_max + 8;
        do begin
            @(posedge clk); #1;
            lat++;
            total++;
            if (busy && done) begin
                bad++;
                $display("FAIL %s busy_and_done: busy=%0b done=%0b want not both", e.name, busy, done);
            end
        end while (!done && lat < limit);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: done=%0b after %0d cycles, want 1", e.name, done, lat);
        end else begin
            total++;
            if (out !== e.out) begin
                bad++;
                $display("FAIL %s out: got=%0d want=%0d", e.name, out, e.out);
            end
            total++;
            if (err !== e.err) begin
                bad++;
                $display("FAIL %s err: got=%0b want=%0b", e.name, err, e.err);
            end
            total++;
            if (lat > e.lat_max) begin
                bad++;
                $display("FAIL %s latency: got=%0d want<=%0d", e.name, lat, e.lat_max);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b1; in1 = 32'd5; in2 = 32'd10;
        go8 = 1'b0; in1_8 = '0; in2_8 = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out, done, busy, err} !== 35'd0) begin
            bad++;
            $display("FAIL reset_values: out=%0d done=%0b busy=%0b err=%0b want all 0", out, done, busy, err);
        end
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_values8: busy=%0b done=%0b want 0 0", busy8, done8);
        end
        go = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_over_go: busy=%0b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        start32("gcd_16_42", 32'd16, 32'd42);
        wait_result(lat);
        total++;
        if (lat != LAT_16_42) begin
            bad++;
            $display("FAIL gcd_16_42 exact_latency: got=%0d want=%0d", lat, LAT_16_42);
        end
    endtask

    task automatic test_zero_operands();
        int lat;
        start32("zero_a", 32'd0, 32'd18);
        wait_result(lat);
        total++;
        if (lat != 1) begin
            bad++;
            $display("FAIL zero_a latency: got=%0d want=1", lat);
        end
        start32("zero_b", 32'd18, 32'd0);
        wait_result(lat);
        start32("zero_both", 32'd0, 32'd0);
        wait_result(lat);
        total++;
        if (lat != 1) begin
            bad++;
            $display("FAIL zero_both latency: got=%0d want=1", lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        push_exp("b2b_first", 32'd21, 32'd14);
        push_exp("b2b_second", 32'd48, 32'd36);
        in1 = 32'd21; in2 = 32'd14; go = 1'b1;
        @(posedge clk); #1;
        // New operands appear while running; they must be ignored until DONE.
        in1 = 32'd48; in2 = 32'd36;
        wait_result(lat);
        @(posedge clk); #1;
        go = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart: done=%0b busy=%0b want 0 1", done, busy);
        end
        total++;
        if (out !== 32'd7) begin
            bad++;
            $display("FAIL b2b_hold_out: got=%0d want=7", out);
        end
        wait_result(lat);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        in1 = 32'd1000; in2 = 32'd7; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midrun_busy: got=%0b want=1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({out, done, busy, err} !== 35'd0) begin
            bad++;
            $display("FAIL midrun_abort: out=%0d done=%0b busy=%0b err=%0b want all 0", out, done, busy, err);
        end
        repeat (4) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL midrun_no_done: done=%0b busy=%0b want 0 0", done, busy);
            end
        end
        start32("after_abort", 32'd1000, 32'd7);
        wait_result(lat);
    endtask

    task automatic run8(input string name, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] want;
        int         bound, lat;
        want  = 8'(ref_gcd({24'd0, x}, {24'd0, y}));
        bound = lat_bound({24'd0, x}, {24'd0, y}, 8);
        in1_8 = x; in2_8 = y; go8 = 1'b1;
        @(posedge clk); #1;
        go8 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done8 && lat < bound + 8);
        total++;
        if (done8 !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: done=%0b after %0d cycles, want 1", name, done8, lat);
        end else begin
            total++;
            if (out8 !== want || err8 !== 1'b0) begin
                bad++;
                $display("FAIL %s out: got=%0d err=%0b want=%0d err=0", name, out8, err8, want);
            end
            total++;
            if (lat > bound) begin
                bad++;
                $display("FAIL %s latency: got=%0d want<=%0d", name, lat, bound);
            end
        end
    endtask

    task automatic test_width8();
        run8("w8_255_1", 8'd255, 8'd1);
        run8("w8_128_64", 8'd128, 8'd64);
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
`ifdef GCD_BINARY_EN
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 15) == 0) x = 32'd0;
            if ($urandom_range(0, 15) == 0) y = 32'd0;
`else
            // Subtractive latency grows with operand magnitude; keep it short.
            x = 32'($urandom_range(0, 63));
            y = 32'($urandom_range(0, 63));
`endif
            start32("random", x, y);
            wait_result(lat);
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_operands();
        test_back_to_back();
        test_reset_mid_run();
        test_width8();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gcd_engine
